discrete_mapper: RTL and testbench

- Parametrised successor to the single-register discrete NES mappers.
- One block covers AxROM, UxROM, CNROM and GxROM, selected by a MODE parameter.
- Runs on the fast system clock instead of clocking registers on raw M2. M2 is synchronised and its falling edge detected; M2 high pulses that are too short are rejected as glitches.
- Sits between the cartridge edge signals and the PRG/CHR memory controller.

---
 rtl/discrete_mapper_pkg.sv | 23 ++
 rtl/discrete_mapper_m2_edge_sync.sv | 45 ++++
 rtl/discrete_mapper.sv | 224 ++++++++++++++++++++++
 tb/tb_discrete_mapper.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/discrete_mapper_pkg.sv
// Shared types and constants for the discrete NES mapper block.
// Contents:
//   mapper_mode_e : board family selected by the MODE parameter
//   wr_state_e    : states of the M2-qualified write capture machine
//   AXROM_NT_BIT  : data bit that selects the single-screen nametable on AxROM
package discrete_mapper_pkg;

  typedef enum logic [1:0] {
    AXROM = 2'd0,
    UXROM = 2'd1,
    CNROM = 2'd2,
    GXROM = 2'd3
  } mapper_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIGH   = 2'd1,
    COMMIT = 2'd2
  } wr_state_e;

  localparam int AXROM_NT_BIT = 4;

endpackage

// File: rtl/discrete_mapper_m2_edge_sync.sv
// Synchronises the raw CPU M2 strobe into the system clock domain and
// produces single-cycle rise/fall pulses of the synchronised level.
// Ports:
//   clk     : system clock (much faster than M2)
//   reset   : asynchronous, active-high
//   m2      : raw CPU M2
//   m2_s    : M2 after a 2-flop synchroniser
//   m2_rise : high for one clk on the first cycle m2_s is high
//   m2_fall : high for one clk on the first cycle m2_s is low
module m2_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic m2,
  output logic m2_s,
  output logic m2_rise,
  output logic m2_fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = m2;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign m2_s    = sync2_q;
  assign m2_rise = sync2_q & ~prev_q;
  assign m2_fall = ~sync2_q & prev_q;

endmodule

// File: rtl/discrete_mapper.sv
// Discrete NES mapper (AxROM / UxROM / CNROM / GxROM) running on the fast
// system clock. CPU writes to $8000-$FFFF are captured while synchronised M2
// is high and committed to the bank registers after M2 falls, provided M2
// stayed high for at least MIN_M2_HIGH clk cycles (shorter pulses are glitches).
// Optional build macro: DISCRETE_MAPPER_BUS_CONFLICT_EN -- when defined the
// committed value is ANDed with the ROM data seen during the write (not AxROM).
// Ports:
//   clk, reset                : system clock, async active-high reset
//   m2, cpu_addr, cpu_rw,
//   cpu_data_in, prg_data_in  : CPU-side cartridge edge signals
//   ppu_addr, ppu_rd, ppu_wr  : PPU-side cartridge edge signals (rd/wr active-low)
//   chr_ram, mirror_v         : board configuration from the ROM header
//   prg_addr, prg_oe          : PRG memory controller address / read enable
//   chr_addr, chr_ce, chr_oe,
//   chr_we                    : CHR memory controller controls
//   ciram_ce, ciram_a10       : console nametable RAM controls
//   bank_wr                   : one-clk pulse when the bank registers change
module discrete_mapper
  import discrete_mapper_pkg::*;
#(
  parameter int MODE          = 0,
  parameter int ADDR_BITS     = 23,
  parameter int PRG_BANK_BITS = 4,
  parameter int CHR_BANK_BITS = 2,
  parameter int MIN_M2_HIGH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m2,
  input  logic [15:0]          cpu_addr,
  input  logic                 cpu_rw,
  input  logic [7:0]           cpu_data_in,
  input  logic [7:0]           prg_data_in,
  input  logic [13:0]          ppu_addr,
  input  logic                 ppu_rd,
  input  logic                 ppu_wr,
  input  logic                 chr_ram,
  input  logic                 mirror_v,
  output logic [ADDR_BITS-1:0] prg_addr,
  output logic                 prg_oe,
  output logic [ADDR_BITS-1:0] chr_addr,
  output logic                 chr_ce,
  output logic                 chr_oe,
  output logic                 chr_we,
  output logic                 ciram_ce,
  output logic                 ciram_a10,
  output logic                 bank_wr
);

  localparam mapper_mode_e MODE_E = mapper_mode_e'(MODE);
  // Wide enough to hold MIN_M2_HIGH (and at least one bit).
  localparam int CNT_W = $clog2(MIN_M2_HIGH + 2);

  logic m2_s, m2_rise, m2_fall;

  m2_edge_sync u_m2_sync (
    .clk     (clk),
    .reset   (reset),
    .m2      (m2),
    .m2_s    (m2_s),
    .m2_rise (m2_rise),
    .m2_fall (m2_fall)
  );

  wr_state_e                state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     wr_req_q, wr_req_d;
  logic [PRG_BANK_BITS-1:0] prg_bank_q, prg_bank_d;
  logic [CHR_BANK_BITS-1:0] chr_bank_q, chr_bank_d;
  logic                     nt_q, nt_d;
  logic                     bank_wr_q, bank_wr_d;
  logic                     capture_en;

  // Captured bus contents; never reset because wr_req_q qualifies them.
  logic [15:0]              wr_addr_q;
  logic [7:0]               wr_data_q;
  logic [7:0]               commit_data;

`ifdef DISCRETE_MAPPER_BUS_CONFLICT_EN
  logic [7:0]               rom_data_q;

  always_ff @(posedge clk) begin
    if (capture_en) rom_data_q <= prg_data_in;
  end

  // AxROM boards drive the data bus without conflict.
  assign commit_data = (MODE_E == AXROM) ? wr_data_q : (wr_data_q & rom_data_q);

  logic unused_capture;
  assign unused_capture = ^wr_addr_q;
`else
  assign commit_data = wr_data_q;

  logic unused_capture;
  assign unused_capture = ^{prg_data_in, wr_addr_q};
`endif

  always_ff @(posedge clk) begin
    if (capture_en) begin
      wr_addr_q <= cpu_addr;
      wr_data_q <= cpu_data_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_req_d   = wr_req_q;
    prg_bank_d = prg_bank_q;
    chr_bank_d = chr_bank_q;
    nt_d       = nt_q;
    bank_wr_d  = 1'b0;
    capture_en = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        wr_req_d = 1'b0;
        if (m2_rise) begin
          state_d    = HIGH;
          cnt_d      = CNT_W'(1);
          capture_en = 1'b1;
        end
      end

      HIGH: begin
        if (m2_fall) begin
          // Qualify on pulse length so M2 glitches never reach the registers.
          if (wr_req_q && (cnt_q >= CNT_W'(MIN_M2_HIGH))) begin
            state_d = COMMIT;
          end else begin
            state_d  = IDLE;
            wr_req_d = 1'b0;
          end
          cnt_d = '0;
        end else begin
          // Re-capture every high cycle so the last one wins.
          capture_en = 1'b1;
          if (cnt_q < CNT_W'(MIN_M2_HIGH)) cnt_d = cnt_q + CNT_W'(1);
        end
      end

      COMMIT: begin
        bank_wr_d = 1'b1;
        case (MODE_E)
          AXROM: begin
            prg_bank_d = PRG_BANK_BITS'(commit_data);
            nt_d       = commit_data[AXROM_NT_BIT];
          end
          UXROM: prg_bank_d = PRG_BANK_BITS'(commit_data);
          CNROM: chr_bank_d = CHR_BANK_BITS'(commit_data);
          default: begin
            prg_bank_d = PRG_BANK_BITS'(commit_data[5:4]);
            chr_bank_d = CHR_BANK_BITS'(commit_data[1:0]);
          end
        endcase
        wr_req_d = 1'b0;
        cnt_d    = '0;
        state_d  = IDLE;
        // A new M2 cycle may already have started; do not lose its first cycle.
        if (m2_s) begin
          state_d    = HIGH;
          cnt_d      = CNT_W'(1);
          capture_en = 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        wr_req_d = 1'b0;
      end
    endcase

    if (capture_en) wr_req_d = cpu_addr[15] & ~cpu_rw;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_req_q   <= 1'b0;
      prg_bank_q <= '0;
      chr_bank_q <= '0;
      nt_q       <= 1'b0;
      bank_wr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_req_q   <= wr_req_d;
      prg_bank_q <= prg_bank_d;
      chr_bank_q <= chr_bank_d;
      nt_q       <= nt_d;
      bank_wr_q  <= bank_wr_d;
    end
  end

  assign bank_wr = bank_wr_q;

  logic [PRG_BANK_BITS-1:0] ux_bank;
  assign ux_bank = cpu_addr[14] ? {PRG_BANK_BITS{1'b1}} : prg_bank_q;

  always_comb begin
    case (MODE_E)
      AXROM, GXROM: prg_addr = ADDR_BITS'({prg_bank_q, cpu_addr[14:0]});
      UXROM:        prg_addr = ADDR_BITS'({ux_bank, cpu_addr[13:0]});
      default:      prg_addr = ADDR_BITS'(cpu_addr[14:0]);
    endcase
  end

  assign prg_oe = cpu_addr[15] & cpu_rw;

  assign chr_addr = ((MODE_E == CNROM) || (MODE_E == GXROM))
                  ? ADDR_BITS'({chr_bank_q, ppu_addr[12:0]})
                  : ADDR_BITS'(ppu_addr[12:0]);

  assign chr_ce    = ~ppu_addr[13];
  assign ciram_ce  = ~ppu_addr[13];
  assign chr_oe    = ~ppu_rd;
  assign chr_we    = chr_ram & ~ppu_wr;
  assign ciram_a10 = (MODE_E == AXROM) ? nt_q
                   : (mirror_v ? ppu_addr[10] : ppu_addr[11]);

endmodule

// File: tb/tb_discrete_mapper.sv
// Testbench for discrete_mapper: one instance per MODE, all fed the same bus.
module tb_discrete_mapper;
  import discrete_mapper_pkg::*;

`ifdef DISCRETE_MAPPER_BUS_CONFLICT_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m2;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_data_in;
  logic [7:0]  prg_data_in;
  logic [13:0] ppu_addr;
  logic        ppu_rd, ppu_wr, chr_ram, mirror_v;

  logic [3:0][22:0] prg_addr_w, chr_addr_w;
  logic [3:0] prg_oe_w, chr_ce_w, chr_oe_w, chr_we_w, ciram_ce_w, ciram_a10_w, bank_wr_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    discrete_mapper #(
      .MODE(g), .ADDR_BITS(23), .PRG_BANK_BITS(4), .CHR_BANK_BITS(2), .MIN_M2_HIGH(4)
    ) u_dut (
      .clk(clk), .reset(reset), .m2(m2),
      .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_data_in(cpu_data_in),
      .prg_data_in(prg_data_in), .ppu_addr(ppu_addr), .ppu_rd(ppu_rd),
      .ppu_wr(ppu_wr), .chr_ram(chr_ram), .mirror_v(mirror_v),
      .prg_addr(prg_addr_w[g]), .prg_oe(prg_oe_w[g]), .chr_addr(chr_addr_w[g]),
      .chr_ce(chr_ce_w[g]), .chr_oe(chr_oe_w[g]), .chr_we(chr_we_w[g]),
      .ciram_ce(ciram_ce_w[g]), .ciram_a10(ciram_a10_w[g]), .bank_wr(bank_wr_w[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int bw_cnt [4];

  // Reference model: bank state per board family.
  int m_prg [4];
  int m_chr [4];
  int m_nt  [4];

  function automatic void model_reset();
    for (int m = 0; m < 4; m++) begin
      m_prg[m] = 0; m_chr[m] = 0; m_nt[m] = 0;
    end
  endfunction

  function automatic void model_commit(input int data, input int rom);
    int d;
    for (int m = 0; m < 4; m++) begin
      d = (BC && m != 0) ? (data & rom) : data;
      case (m)
        0: begin m_prg[m] = d % 16; m_nt[m] = (d / 16) % 2; end
        1: m_prg[m] = d % 16;
        2: m_chr[m] = d % 4;
        default: begin m_prg[m] = (d / 16) % 4; m_chr[m] = d % 4; end
      endcase
    end
  endfunction

  function automatic int model_prg(input int m, input int a);
    case (m)
      0, 3: return m_prg[m] * 32768 + a % 32768;
      1:    return ((a / 16384) % 2 == 1 ? 15 : m_prg[m]) * 16384 + a % 16384;
      default: return a % 32768;
    endcase
  endfunction

  function automatic int model_chr(input int m, input int p);
    if (m == 2 || m == 3) return m_chr[m] * 8192 + p % 8192;
    return p % 8192;
  endfunction

  function automatic int model_a10(input int m, input int p, input int mv);
    if (m == 0) return m_nt[m];
    return mv ? (p / 1024) % 2 : (p / 2048) % 2;
  endfunction

  // One CPU cycle with M2 high for 'width' clks, then watch for bank_wr.
  task automatic m2_cycle(input int width, input logic [15:0] addr, input logic rw,
                          input logic [7:0] data, input logic [7:0] rom);
    @(negedge clk);
    cpu_addr = addr; cpu_rw = rw; cpu_data_in = data; prg_data_in = rom; m2 = 1'b1;
    repeat (width) @(negedge clk);
    m2 = 1'b0;
    for (int g = 0; g < 4; g++) bw_cnt[g] = 0;
    repeat (14) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) if (bank_wr_w[g]) bw_cnt[g]++;
    end
    cpu_rw = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; m2 = 1'b0; cpu_addr = 16'h8000; cpu_rw = 1'b1; cpu_data_in = 8'h00;
    prg_data_in = 8'hFF; ppu_addr = 14'h0000; ppu_rd = 1'b1; ppu_wr = 1'b1;
    chr_ram = 1'b0; mirror_v = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (bank_wr_w[g] !== 1'b0) begin
        errors++; $display("FAIL reset_bank_wr inst%0d: got %b expected 0", g, bank_wr_w[g]);
      end
      checks++;
      if (prg_addr_w[g] !== 23'h0) begin
        errors++; $display("FAIL reset_prg_addr inst%0d: got %h expected 0", g, prg_addr_w[g]);
      end
    end
    checks++;
    if (g_dut[0].u_dut.state_q !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected IDLE", g_dut[0].u_dut.state_q);
    end
  endtask

  task automatic test_glitch();
    m2_cycle(2, 16'h8000, 1'b0, 8'h07, 8'hFF);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (bw_cnt[g] !== 0) begin
        errors++; $display("FAIL glitch_bank_wr inst%0d: got %0d pulses expected 0", g, bw_cnt[g]);
      end
    end
    cpu_addr = 16'h8000; #1;
    checks++;
    if (prg_addr_w[0] !== 23'h0) begin
      errors++; $display("FAIL glitch_prg_bank: got %h expected 0", prg_addr_w[0]);
    end
  endtask

  task automatic test_axrom();
    m2_cycle(10, 16'h8000, 1'b0, 8'h15, 8'hFF);
    model_commit(8'h15, 8'hFF);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (bw_cnt[g] !== 1) begin
        errors++; $display("FAIL axrom_bank_wr inst%0d: got %0d pulses expected 1", g, bw_cnt[g]);
      end
    end
    cpu_addr = 16'h9234; ppu_addr = 14'h0000; #1;
    checks++;
    if (prg_addr_w[0] !== 23'h029234) begin
      errors++; $display("FAIL axrom_prg_addr: got %h expected 029234", prg_addr_w[0]);
    end
    checks++;
    if (ciram_a10_w[0] !== 1'b1) begin
      errors++; $display("FAIL axrom_ciram_a10: got %b expected 1", ciram_a10_w[0]);
    end
  endtask

  task automatic test_uxrom();
    m2_cycle(10, 16'hC000, 1'b0, 8'h03, 8'hFF);
    model_commit(8'h03, 8'hFF);
    checks++;
    if (bw_cnt[1] !== 1) begin
      errors++; $display("FAIL uxrom_bank_wr: got %0d pulses expected 1", bw_cnt[1]);
    end
    cpu_addr = 16'h8123; #1;
    checks++;
    if (prg_addr_w[1] !== 23'h00C123) begin
      errors++; $display("FAIL uxrom_low: got %h expected 00C123", prg_addr_w[1]);
    end
    cpu_addr = 16'hC123; #1;
    checks++;
    if (prg_addr_w[1] !== 23'h03C123) begin
      errors++; $display("FAIL uxrom_fixed: got %h expected 03C123", prg_addr_w[1]);
    end
  endtask

  task automatic test_cnrom();
    m2_cycle(10, 16'h8000, 1'b0, 8'hFE, 8'hFF);
    model_commit(8'hFE, 8'hFF);
    ppu_addr = 14'h0456; #1;
    checks++;
    if (chr_addr_w[2] !== 23'h004456) begin
      errors++; $display("FAIL cnrom_chr_addr: got %h expected 004456", chr_addr_w[2]);
    end
  endtask

  task automatic test_reset_mid_high();
    @(negedge clk);
    cpu_addr = 16'h8000; cpu_rw = 1'b0; cpu_data_in = 8'h1F; m2 = 1'b1;
    repeat (8) @(negedge clk);
    reset = 1'b1; m2 = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int g = 0; g < 4; g++) bw_cnt[g] = 0;
    repeat (14) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) if (bank_wr_w[g]) bw_cnt[g]++;
    end
    cpu_rw = 1'b1;
    checks++;
    if (bw_cnt[0] !== 0) begin
      errors++; $display("FAIL rstmid_bank_wr: got %0d pulses expected 0", bw_cnt[0]);
    end
    cpu_addr = 16'h8000; ppu_addr = 14'h1FFF; #1;
    checks++;
    if (prg_addr_w[1] !== 23'h0) begin
      errors++; $display("FAIL rstmid_ux_bank: got %h expected 0", prg_addr_w[1]);
    end
    checks++;
    if (chr_addr_w[2] !== 23'h001FFF) begin
      errors++; $display("FAIL rstmid_cn_bank: got %h expected 001FFF", chr_addr_w[2]);
    end
    checks++;
    if (ciram_a10_w[0] !== 1'b0) begin
      errors++; $display("FAIL rstmid_nt: got %b expected 0", ciram_a10_w[0]);
    end
    checks++;
    if (g_dut[0].u_dut.state_q !== IDLE) begin
      errors++; $display("FAIL rstmid_state: got %0d expected IDLE", g_dut[0].u_dut.state_q);
    end
  endtask

  task automatic test_bus_conflict();
    logic [22:0] exp;
    m2_cycle(10, 16'h8000, 1'b0, 8'h0F, 8'h05);
    model_commit(8'h0F, 8'h05);
    exp = BC ? 23'h014000 : 23'h03C000;
    cpu_addr = 16'h8000; #1;
    checks++;
    if (prg_addr_w[1] !== exp) begin
      errors++; $display("FAIL bus_conflict_ux: got %h expected %h", prg_addr_w[1], exp);
    end
  endtask

  // Random reads of every combinational mapping against the model.
  task automatic test_mapping(input int n);
    int e;
    for (int k = 0; k < n; k++) begin
      cpu_addr = 16'($urandom); cpu_rw = 1'($urandom); ppu_addr = 14'($urandom);
      ppu_rd = 1'($urandom); ppu_wr = 1'($urandom); chr_ram = 1'($urandom);
      mirror_v = 1'($urandom);
      #1;
      for (int g = 0; g < 4; g++) begin
        e = model_prg(g, int'(cpu_addr));
        checks++;
        if (prg_addr_w[g] !== 23'(e)) begin
          errors++; $display("FAIL map_prg inst%0d a=%h: got %h expected %h", g, cpu_addr, prg_addr_w[g], e);
        end
        e = model_chr(g, int'(ppu_addr));
        checks++;
        if (chr_addr_w[g] !== 23'(e)) begin
          errors++; $display("FAIL map_chr inst%0d p=%h: got %h expected %h", g, ppu_addr, chr_addr_w[g], e);
        end
        e = model_a10(g, int'(ppu_addr), int'(mirror_v));
        checks++;
        if (ciram_a10_w[g] !== 1'(e)) begin
          errors++; $display("FAIL map_a10 inst%0d: got %b expected %0d", g, ciram_a10_w[g], e);
        end
        checks++;
        if ({prg_oe_w[g], chr_ce_w[g], ciram_ce_w[g], chr_oe_w[g], chr_we_w[g]} !==
            {cpu_addr >= 16'h8000 && cpu_rw, ppu_addr < 14'h2000, ppu_addr < 14'h2000,
             !ppu_rd, chr_ram && !ppu_wr}) begin
          errors++; $display("FAIL map_ctl inst%0d: got %b%b%b%b%b", g, prg_oe_w[g],
                             chr_ce_w[g], ciram_ce_w[g], chr_oe_w[g], chr_we_w[g]);
        end
      end
      @(negedge clk);
    end
    ppu_rd = 1'b1; ppu_wr = 1'b1; cpu_rw = 1'b1;
  endtask

  task automatic test_random_writes(input int n);
    int w, exp_p;
    logic [15:0] a;
    logic rw;
    logic [7:0] d, r;
    for (int k = 0; k < n; k++) begin
      w = $urandom_range(1, 10);
      a = 16'($urandom);
      rw = ($urandom % 4) == 0;
      d = 8'($urandom);
      r = 8'($urandom);
      m2_cycle(w, a, rw, d, r);
      exp_p = (a >= 16'h8000 && !rw && w >= 4) ? 1 : 0;
      if (exp_p == 1) model_commit(int'(d), int'(r));
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (bw_cnt[g] !== exp_p) begin
          errors++; $display("FAIL rand_bank_wr inst%0d w=%0d a=%h rw=%b: got %0d expected %0d",
                             g, w, a, rw, bw_cnt[g], exp_p);
        end
      end
      test_mapping(3);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_axrom();
    test_uxrom();
    test_cnrom();
    test_mapping(8);
    test_reset_mid_high();
    test_bus_conflict();
    test_random_writes(30);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
